// File: rtl/render_cfg_pkg.sv
// render_cfg_pkg
//   Shared definitions for the renderer configuration master: register map
//   of the configuration slave, burst length, FSM state encoding and the
//   write-data source selector used by the write sequencer.
package render_cfg_pkg;

    localparam logic [15:0] CFG_FB_BASE    = 16'h0000;
    localparam logic [15:0] CFG_VB_BASE    = 16'h0004;
    localparam logic [15:0] CFG_START      = 16'h0008;  // also the done register
    localparam logic [15:0] CFG_MV_BASE    = 16'h0100;
    localparam logic [15:0] CFG_MVP_BASE   = 16'h0200;
    localparam logic [15:0] CFG_LIGHT_BASE = 16'h0300;

    localparam int unsigned CFG_NUM_WRITES = 38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_POLL_WAIT,
        ST_RD,
        ST_RD_DATA
    } cfg_state_t;

    typedef enum logic [2:0] {
        SEL_FB,
        SEL_VB,
        SEL_MV,
        SEL_MVP,
        SEL_LIGHT,
        SEL_ONE
    } data_sel_t;

endpackage

// File: rtl/cfg_wr_seq.sv
// cfg_wr_seq
//   Maps the configuration write index (0..37) to the slave byte address,
//   the write-data source and the word index within that source.
//   idx  : write index
//   addr : Avalon byte address for this write
//   sel  : which latched config source supplies the data
//   word : word index within the matrix / lighting source
module cfg_wr_seq
    import render_cfg_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [15:0] addr,
    output data_sel_t   sel,
    output logic [3:0]  word
);

    always_comb begin
        addr = CFG_START;
        sel  = SEL_ONE;
        word = '0;
        if (idx == 6'd0) begin
            addr = CFG_FB_BASE;
            sel  = SEL_FB;
        end else if (idx == 6'd1) begin
            addr = CFG_VB_BASE;
            sel  = SEL_VB;
        end else if (idx < 6'd18) begin
            word = 4'(idx - 6'd2);
            addr = CFG_MV_BASE + {10'b0, word, 2'b00};
            sel  = SEL_MV;
        end else if (idx < 6'd34) begin
            word = 4'(idx - 6'd18);
            addr = CFG_MVP_BASE + {10'b0, word, 2'b00};
            sel  = SEL_MVP;
        end else if (idx < 6'd37) begin
            word = 4'(idx - 6'd34);
            addr = CFG_LIGHT_BASE + {10'b0, word, 2'b00};
            sel  = SEL_LIGHT;
        end
    end

endmodule

// File: rtl/render_cfg_master.sv
// render_cfg_master
//   Avalon-MM master that latches a frame configuration on start, writes it
//   to the renderer register file, kicks the start register, then polls the
//   done register until it reads 1 (done) or the poll limit is hit (timeout).
//   clk, reset           : clock, asynchronous active-high reset
//   start                : frame request, honoured only when idle
//   fb_base, vb_base     : buffer bases (26 bit)
//   mv_in, mvp_in        : 16 x 32-bit matrices, word i at [32i +: 32]
//   light_in             : 3 x 32-bit lighting words, word i at [32i +: 32]
//   busy, done, timeout  : status; done/timeout are single-cycle pulses
//   address, write, read, writedata, waitrequest, readdata : Avalon-MM master
module render_cfg_master
    import render_cfg_pkg::*;
#(
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned POLL_LIMIT   = 65535,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [25:0]  fb_base,
    input  logic [25:0]  vb_base,
    input  logic [511:0] mv_in,
    input  logic [511:0] mvp_in,
    input  logic [95:0]  light_in,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [15:0]  address,
    output logic         write,
    output logic         read,
    output logic [31:0]  writedata,
    input  logic         waitrequest,
    input  logic [31:0]  readdata
);

    localparam logic [5:0]  LAST_IDX = 6'(CFG_NUM_WRITES - 1);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [15:0] LAT_LAST = 16'(READ_LATENCY - 1);
    localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);

    cfg_state_t        state, state_nx;
    logic [5:0]        idx;
    logic [15:0]       gap_cnt, lat_cnt, poll_cnt;
    logic [25:0]       fb_q, vb_q;
    logic [15:0][31:0] mv_q, mvp_q;
    logic [2:0][31:0]  light_q;

    logic [15:0] seq_addr;
    data_sel_t   seq_sel;
    logic [3:0]  seq_word;
    logic [31:0] wr_data;
    logic        unused_rd;

    assign unused_rd = ^readdata[31:1];

    cfg_wr_seq u_seq (
        .idx  (idx),
        .addr (seq_addr),
        .sel  (seq_sel),
        .word (seq_word)
    );

    always_comb begin
        wr_data = 32'h0000_0001;
        case (seq_sel)
            SEL_FB:    wr_data = {6'b0, fb_q};
            SEL_VB:    wr_data = {6'b0, vb_q};
            SEL_MV:    wr_data = mv_q[seq_word];
            SEL_MVP:   wr_data = mvp_q[seq_word];
            SEL_LIGHT: wr_data = light_q[seq_word[1:0]];
            default:   wr_data = 32'h0000_0001;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            gap_cnt  <= '0;
            lat_cnt  <= '0;
            poll_cnt <= '0;
            fb_q     <= '0;
            vb_q     <= '0;
            mv_q     <= '0;
            mvp_q    <= '0;
            light_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                idx     <= '0;
                fb_q    <= fb_base;
                vb_q    <= vb_base;
                mv_q    <= mv_in;
                mvp_q   <= mvp_in;
                light_q <= light_in;
            end
            if (state == ST_WR && !waitrequest)
                idx <= idx + 6'd1;
            // Counters run only while in their own state and restart from 0
            // on every entry.
            gap_cnt <= (state == ST_POLL_WAIT) ? gap_cnt + 16'd1 : '0;
            lat_cnt <= (state == ST_RD_DATA)   ? lat_cnt + 16'd1 : '0;
            if (state == ST_WR)
                poll_cnt <= '0;
            else if (state == ST_RD && !waitrequest && poll_cnt != '1)
                poll_cnt <= poll_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        timeout   = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        address   = '0;
        writedata = '0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = ST_WR;
            end
            ST_WR: begin
                write     = 1'b1;
                address   = seq_addr;
                writedata = wr_data;
                if (!waitrequest && idx == LAST_IDX)
                    state_nx = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (gap_cnt == GAP_LAST)
                    state_nx = ST_RD;
            end
            ST_RD: begin
                read    = 1'b1;
                address = CFG_START;
                if (!waitrequest)
                    state_nx = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (lat_cnt == LAT_LAST) begin
                    if (readdata[0]) begin
                        done     = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (poll_cnt == LIMIT) begin
                        timeout  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_POLL_WAIT;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_render_cfg_master.sv
// tb_render_cfg_master
//   Directed bench for render_cfg_master with POLL_GAP=4, POLL_LIMIT=5,
//   READ_LATENCY=2 and a small Avalon slave responder.
module tb_render_cfg_master;

    localparam int GAP = 4;
    localparam int LIM = 5;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [25:0]  fb_base, vb_base;
    logic [511:0] mv_in, mvp_in;
    logic [95:0]  light_in;
    logic         busy, done, timeout;
    logic [15:0]  address;
    logic         write, read;
    logic [31:0]  writedata;
    logic         waitrequest = 1'b0;
    logic [31:0]  readdata = 32'hFFFF_FFFE;

    render_cfg_master #(
        .POLL_GAP     (GAP),
        .POLL_LIMIT   (LIM),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .fb_base     (fb_base),
        .vb_base     (vb_base),
        .mv_in       (mv_in),
        .mvp_in      (mvp_in),
        .light_in    (light_in),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .address     (address),
        .write       (write),
        .read        (read),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Controls written only by the stimulus process
    int zeros_before_one = 0;
    bit stall_mode = 0;
    int rd_base = 0;

    // Monitor / slave state written only by the monitor process
    int          ecount = 0;
    logic [47:0] wtrace[$];
    int          wr_edges[$];
    int          rd_edges[$];
    int          done_cnt = 0, to_cnt = 0, stall_viol = 0, both_viol = 0;
    int          rd_acc_edge = -100;
    logic [31:0] resp = 32'h0;
    logic        prev_stalled = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) begin
        ecount++;
        if (write && read) both_viol++;
        if (prev_stalled && (!write || address !== prev_addr || writedata !== prev_data))
            stall_viol++;
        prev_stalled = write && waitrequest;
        prev_addr    = address;
        prev_data    = writedata;
        if (write && !waitrequest) begin
            wtrace.push_back({address, writedata});
            wr_edges.push_back(ecount);
        end
        if (read && !waitrequest) begin
            resp = ((rd_edges.size() - rd_base) < zeros_before_one) ? 32'hFFFF_FFFE : 32'h8000_0001;
            rd_edges.push_back(ecount);
            rd_acc_edge = ecount;
        end
        if (done) done_cnt++;
        if (timeout) to_cnt++;
        #1;
        readdata    = (ecount == rd_acc_edge + LAT - 1) ? resp : 32'hFFFF_FFFE;
        waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    function automatic logic [47:0] exp_wr(input int k);
        if (k == 0)      return {16'h0000, 32'h0012_3456};
        else if (k == 1) return {16'h0004, 32'h0030_0000};
        else if (k < 18) return {16'(16'h0100 + 4 * (k - 2)),  32'(k - 2)};
        else if (k < 34) return {16'(16'h0200 + 4 * (k - 18)), 32'(32'h100 + k - 18)};
        else if (k < 37) return {16'(16'h0300 + 4 * (k - 34)), 32'(7 + k - 34)};
        else             return {16'h0008, 32'h0000_0001};
    endfunction

    task automatic check_trace(input string tag, input int base);
        check({tag, "_nwr"}, 64'(wtrace.size() - base), 64'd38);
        for (int k = 0; k < 38 && base + k < wtrace.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), 64'(wtrace[base + k]), 64'(exp_wr(k)));
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || timeout) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int bw, br, bd, bt;
    bit ok;

    initial begin
        fb_base  = 26'h0123456;
        vb_base  = 26'h0300000;
        for (int i = 0; i < 16; i++) begin
            mv_in[32 * i +: 32]  = 32'(i);
            mvp_in[32 * i +: 32] = 32'(32'h100 + i);
        end
        light_in = {32'd9, 32'd8, 32'd7};

        repeat (3) @(negedge clk);
        check("rst_status", 64'({busy, done, timeout, write, read}), 64'd0);
        check("rst_addr", 64'(address), 64'd0);
        check("rst_wdata", 64'(writedata), 64'd0);
        reset = 1'b0;

        // Zero-stall burst, three 0 polls then 1
        bw = wtrace.size(); br = rd_edges.size(); bd = done_cnt; bt = to_cnt;
        rd_base = br; zeros_before_one = 3; stall_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("first_wr", 64'({busy, write, address, writedata}), {30'd0, 1'b1, 1'b1, 16'h0000, 32'h0012_3456});
        @(negedge clk);
        start = 1'b0;
        wait_end(2000, ok);
        check("t1_end_seen", 64'(ok), 64'd1);
        check("t1_busy_end", 64'({busy, done}), 64'b11);
        @(negedge clk);
        check("t1_busy_after", 64'({busy, done, timeout}), 64'd0);
        check_trace("t1", bw);
        check("t1_wr_span", 64'(wr_edges[bw + 37] - wr_edges[bw]), 64'd37);
        check("t1_nrd", 64'(rd_edges.size() - br), 64'd4);
        check("t1_first_rd", 64'(rd_edges[br] - wr_edges[bw + 37]), 64'(GAP + 1));
        for (int i = 1; i < 4; i++)
            check($sformatf("t1_rd_gap%0d", i), 64'(rd_edges[br + i] - rd_edges[br + i - 1]), 64'(LAT + GAP + 1));
        check("t1_done", 64'(done_cnt - bd), 64'd1);
        check("t1_timeout", 64'(to_cnt - bt), 64'd0);

        // Random stalls during the burst, done on first poll
        bw = wtrace.size(); br = rd_edges.size(); bd = done_cnt;
        rd_base = br; zeros_before_one = 0; stall_mode = 1;
        pulse_start();
        wait_end(3000, ok);
        stall_mode = 0;
        check("t2_end_seen", 64'(ok), 64'd1);
        @(negedge clk);
        check_trace("t2", bw);
        check("t2_stall_stable", 64'(stall_viol), 64'd0);
        check("t2_done", 64'(done_cnt - bd), 64'd1);

        // Done never set: timeout after exactly LIM polls
        bw = wtrace.size(); br = rd_edges.size(); bd = done_cnt; bt = to_cnt;
        rd_base = br; zeros_before_one = 1000;
        pulse_start();
        wait_end(2000, ok);
        check("t3_end_seen", 64'({ok, timeout, busy}), 64'b111);
        @(negedge clk);
        check("t3_nwr", 64'(wtrace.size() - bw), 64'd38);
        check("t3_nrd", 64'(rd_edges.size() - br), 64'(LIM));
        check("t3_timeout", 64'(to_cnt - bt), 64'd1);
        check("t3_no_done", 64'(done_cnt - bd), 64'd0);

        // start pulsed mid-burst with altered inputs is ignored
        bw = wtrace.size(); br = rd_edges.size(); bd = done_cnt; bt = to_cnt;
        rd_base = br; zeros_before_one = 0;
        pulse_start();
        for (int i = 0; i < 200 && wtrace.size() - bw < 10; i++) @(negedge clk);
        check("t4_reach10", 64'(wtrace.size() - bw), 64'd10);
        start = 1'b1;
        light_in = {32'hDEAD, 32'hBEEF, 32'hCAFE};
        @(negedge clk);
        start = 1'b0;
        light_in = {32'd9, 32'd8, 32'd7};
        wait_end(2000, ok);
        check("t4_end_seen", 64'(ok), 64'd1);
        repeat (80) @(negedge clk);
        check_trace("t4", bw);
        check("t4_one_done", 64'(done_cnt - bd), 64'd1);
        check("t4_no_timeout", 64'(to_cnt - bt), 64'd0);

        // Reset at write 20, then a fresh burst from 0x000
        bw = wtrace.size();
        pulse_start();
        for (int i = 0; i < 200 && wtrace.size() - bw < 20; i++) @(negedge clk);
        check("t5_reach20", 64'(wtrace.size() - bw), 64'd20);
        reset = 1'b1;
        #1;
        check("t5_rst_drop", 64'({write, busy, read}), 64'd0);
        check("t5_rst_addr", 64'(address), 64'd0);
        @(negedge clk);
        check("t5_rst_nwr", 64'(wtrace.size() - bw), 64'd20);
        reset = 1'b0;
        bw = wtrace.size(); br = rd_edges.size(); bd = done_cnt;
        rd_base = br; zeros_before_one = 1;
        pulse_start();
        wait_end(2000, ok);
        check("t5_end_seen", 64'(ok), 64'd1);
        @(negedge clk);
        check_trace("t5", bw);
        check("t5_nrd", 64'(rd_edges.size() - br), 64'd2);
        check("t5_done", 64'(done_cnt - bd), 64'd1);
        check("never_wr_and_rd", 64'(both_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
